// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mult_div_pkg;

  // Operation select, as driven by the control unit.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // High bit of the encoding selects divide.
  function automatic logic op_is_div(input op_e i_op);
    return i_op[1];
  endfunction

  // Low bit clear means the operands are two's complement.
  function automatic logic op_is_signed(input op_e i_op);
    return ~i_op[0];
  endfunction

endpackage

// File: rtl/mult_div_sign_fix.sv
// Final sign correction: turns the magnitude result into signed hi/lo.
module mult_div_sign_fix
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_raw,
  input  op_e                i_op,
  input  logic               i_neg_a,
  input  logic               i_neg_b,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic               w_neg_a;
  logic               w_neg_b;
  logic [W2-1:0]      w_prod;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo;

  // Negate product/quotient when signs differ; remainder follows the dividend.
  always_comb begin
    w_neg_a = i_neg_a & op_is_signed(i_op);
    w_neg_b = i_neg_b & op_is_signed(i_op);
    w_prod  = i_raw;
    w_rem   = i_raw[W2-1:WIDTH];
    w_quo   = i_raw[WIDTH-1:0];
    o_hi    = '0;
    o_lo    = '0;
    if (w_neg_a ^ w_neg_b) begin
      w_prod = -i_raw;
      w_quo  = -i_raw[WIDTH-1:0];
    end
    if (w_neg_a) begin
      w_rem = -i_raw[W2-1:WIDTH];
    end
    if (op_is_div(i_op)) begin
      o_hi = w_rem;
      o_lo = w_quo;
    end else begin
      o_hi = w_prod[W2-1:WIDTH];
      o_lo = w_prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and divide with start/done handshake.
// One result bit per RUN cycle on operand magnitudes, sign fixed up in FIX.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  op_e                r_op;
  logic               r_neg_a;
  logic               r_neg_b;
  logic [WIDTH-1:0]   r_mag_op;
  logic [W2-1:0]      r_acc;
  logic               r_dbz_pend;
  logic               r_fix_wait;
  logic               r_busy;
  logic               r_done;
  logic               r_div_by_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  op_e                w_op;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_b_zero;
  logic               w_is_dbz;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_add;
  logic [W2-1:0]      w_mul_nxt;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_sub;
  logic [W2-1:0]      w_div_nxt;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Operand decode: sign flags only for signed ops, magnitudes for the core.
  always_comb begin
    w_op     = op_e'(op);
    w_neg_a  = op_is_signed(w_op) & a[WIDTH-1];
    w_neg_b  = op_is_signed(w_op) & b[WIDTH-1];
    w_mag_a  = w_neg_a ? -a : a;
    w_mag_b  = w_neg_b ? -b : b;
    w_b_zero = (b == '0);
    w_is_dbz = op_is_div(w_op) & w_b_zero;
  end

  // One iteration step for both algorithms; acc holds {hi_part, lo_part}.
  // Divide: acc = {remainder, dividend/quotient}; a clear top bit of the
  // trial subtraction means the divisor fits and the quotient bit is 1.
  always_comb begin
    w_addend  = r_acc[0] ? r_mag_op : '0;
    w_add     = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, w_addend};
    w_mul_nxt = {w_add, r_acc[WIDTH-1:1]};
    w_shl     = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
    w_sub     = w_shl - {1'b0, r_mag_op};
    if (!w_sub[WIDTH]) begin
      w_div_nxt = {w_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_div_nxt = {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  mult_div_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .i_raw   (r_acc),
    .i_op    (r_op),
    .i_neg_a (r_neg_a),
    .i_neg_b (r_neg_b),
    .o_hi    (w_fix_hi),
    .o_lo    (w_fix_lo)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; divide-by-zero skips RUN and spends two cycles in FIX.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_is_dbz ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        if (!r_fix_wait) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt         <= '0;
      r_op          <= OP_MULT;
      r_neg_a       <= 1'b0;
      r_neg_b       <= 1'b0;
      r_mag_op      <= '0;
      r_acc         <= '0;
      r_dbz_pend    <= 1'b0;
      r_fix_wait    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op          <= w_op;
            r_neg_a       <= w_neg_a;
            r_neg_b       <= w_neg_b;
            r_cnt         <= CNT_W'(WIDTH);
            r_div_by_zero <= 1'b0;
            r_dbz_pend    <= w_is_dbz;
            r_fix_wait    <= w_is_dbz;
            if (op_is_div(w_op)) begin
              r_mag_op <= w_mag_b;
              r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
            end else begin
              r_mag_op <= w_mag_a;
              r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          r_acc <= op_is_div(r_op) ? w_div_nxt : w_mul_nxt;
        end
        S_FIX: begin
          r_fix_wait <= 1'b0;
          if (w_state_nxt == S_DONE) begin
            if (r_dbz_pend) begin
              r_div_by_zero <= 1'b1;
            end else begin
              r_hi <= w_fix_hi;
              r_lo <= w_fix_lo;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
